// File: rtl/pcsp_and_memory_block.sv
`default_nettype none
// pcsp_and_memory_block: PC, SP, IR and unified word memory for the 16-bit multicycle datapath.
// Revision 1.0

module pcsp_and_memory_block #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [15:0] SP_RESET  = 16'h0000,
  parameter logic [15:0] PC_RESET  = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  MemSrc,
  input  logic [2:0]  MemDst,
  input  logic [15:0] ze_imm,
  input  logic [15:0] ls_imm,
  input  logic [15:0] MaryData,
  input  logic [15:0] ShelleyData,
  input  logic [15:0] RAData,
  input  logic [15:0] CompData,
  input  logic [2:0]  PCSrc,
  input  logic [2:0]  SPSrc,
  input  logic        PCWrite,
  input  logic        SPWrite,
  input  logic        InstWrite,
  output logic [15:0] MemVal_out,
  output logic [15:0] Inst_out,
  output logic [15:0] pc_out,
  output logic [15:0] sp_out
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [15:0]   pc;
  logic [15:0]   sp;
  logic [15:0]   ir;
  logic [15:0]   mem [MEM_WORDS];
  logic [15:0]   mem_addr;
  logic [15:0]   wr_data;
  logic [15:0]   pc_plus2;
  logic [15:0]   pc_next;
  logic [15:0]   sp_next;
  logic [AW-1:0] word_idx;

  assign pc_plus2 = pc + 16'd2;

  always_comb begin
    mem_addr = pc;
    case (MemSrc)
      2'd0:    mem_addr = pc;
      2'd1:    mem_addr = sp;
      2'd2:    mem_addr = ze_imm;
      default: mem_addr = CompData;
    endcase
  end

  always_comb begin
    wr_data = 16'h0000;
    case (MemDst)
      3'd0:    wr_data = CompData;
      3'd1:    wr_data = MaryData;
      3'd2:    wr_data = ShelleyData;
      3'd3:    wr_data = RAData;
      3'd4:    wr_data = pc_plus2;
      3'd5:    wr_data = ze_imm;
      3'd6:    wr_data = ls_imm;
      default: wr_data = 16'h0000;
    endcase
  end

  // Byte address to word index; upper bits drop out so large addresses alias.
  assign word_idx   = AW'(mem_addr >> 1);
  assign MemVal_out = mem[word_idx];

  always_comb begin
    pc_next = pc;
    case (PCSrc)
      3'd0:    pc_next = pc_plus2;
      3'd1:    pc_next = pc + ls_imm;
      3'd2:    pc_next = ze_imm;
      3'd3:    pc_next = RAData;
      3'd4:    pc_next = MemVal_out;
      3'd5:    pc_next = CompData;
      default: pc_next = pc;
    endcase
  end

  always_comb begin
    sp_next = sp;
    case (SPSrc)
      3'd0:    sp_next = sp - 16'd2;
      3'd1:    sp_next = sp + 16'd2;
      3'd2:    sp_next = sp + ls_imm;
      3'd3:    sp_next = MaryData;
      3'd4:    sp_next = CompData;
      default: sp_next = sp;
    endcase
  end

  // Memory is never cleared by reset, only write-blocked.
  always_ff @(posedge clock) begin
    if (!reset && MemWrite) begin
      mem[word_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= PC_RESET;
      sp <= SP_RESET;
      ir <= 16'h0000;
    end else begin
      if (PCWrite)   pc <= pc_next;
      if (SPWrite)   sp <= sp_next;
      if (InstWrite) ir <= MemVal_out;
    end
  end

  assign pc_out   = pc;
  assign sp_out   = sp;
  assign Inst_out = ir;

endmodule

`default_nettype wire

// File: tb/tb_pcsp_and_memory_block.sv
`default_nettype none
// tb_pcsp_and_memory_block: directed vector table plus hand sequences for pcsp_and_memory_block.
// Revision 1.0

module tb_pcsp_and_memory_block;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [1:0]  MemSrc;
  logic [2:0]  MemDst;
  logic [15:0] ze_imm, ls_imm, MaryData, ShelleyData, RAData, CompData;
  logic [2:0]  PCSrc, SPSrc;
  logic        PCWrite, SPWrite, InstWrite;
  logic [15:0] MemVal_out, Inst_out, pc_out, sp_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pcsp_and_memory_block dut (
    .clock(clock), .reset(reset), .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst),
    .ze_imm(ze_imm), .ls_imm(ls_imm), .MaryData(MaryData), .ShelleyData(ShelleyData),
    .RAData(RAData), .CompData(CompData), .PCSrc(PCSrc), .SPSrc(SPSrc),
    .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
    .MemVal_out(MemVal_out), .Inst_out(Inst_out), .pc_out(pc_out), .sp_out(sp_out)
  );

  typedef struct {
    logic        rst, mw;
    logic [1:0]  msrc;
    logic [2:0]  mdst;
    logic [15:0] ze, ls, mary, shel, ra, comp;
    logic [2:0]  pcsrc;
    logic        pcw;
    logic [2:0]  spsrc;
    logic        spw, iw;
    logic [15:0] epc, esp, eir, emem;
  } vec_t;

  localparam int NV = 26;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic rst, input logic mw, input logic [1:0] msrc, input logic [2:0] mdst,
    input logic [15:0] ze, input logic [15:0] ls, input logic [15:0] mary,
    input logic [15:0] shel, input logic [15:0] ra, input logic [15:0] comp,
    input logic [2:0] pcsrc, input logic pcw, input logic [2:0] spsrc, input logic spw,
    input logic iw, input logic [15:0] epc, input logic [15:0] esp,
    input logic [15:0] eir, input logic [15:0] emem);
    vec_t v;
    v.rst = rst; v.mw = mw; v.msrc = msrc; v.mdst = mdst;
    v.ze = ze; v.ls = ls; v.mary = mary; v.shel = shel; v.ra = ra; v.comp = comp;
    v.pcsrc = pcsrc; v.pcw = pcw; v.spsrc = spsrc; v.spw = spw; v.iw = iw;
    v.epc = epc; v.esp = esp; v.eir = eir; v.emem = emem;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; MemWrite = v.mw; MemSrc = v.msrc; MemDst = v.mdst;
    ze_imm = v.ze; ls_imm = v.ls; MaryData = v.mary; ShelleyData = v.shel;
    RAData = v.ra; CompData = v.comp; PCSrc = v.pcsrc; PCWrite = v.pcw;
    SPSrc = v.spsrc; SPWrite = v.spw; InstWrite = v.iw;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //             rst mw ms md ze        ls        mary      shel      ra        comp      pcs pw sps sw iw  pc        sp        ir        mem
    tv[0]  = mk(1, 1, 0, 1, 16'h0010, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 2, 1, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tv[1]  = mk(0, 1, 0, 1, 16'h0002, 16'h0000, 16'd100,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 16'h0000, 16'h0002, 16'h0000, 16'd100);
    tv[2]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 16'h0002, 16'd100,  16'd100);
    tv[3]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0002, 16'h0002, 16'd100,  16'h0000);
    tv[4]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0004, 16'h0002, 16'd100,  16'h0000);
    tv[5]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0006, 16'h0002, 16'd100,  16'h0000);
    tv[6]  = mk(0, 0, 0, 0, 16'h0000, 16'hFFFC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 16'h0002, 16'h0002, 16'd100,  16'h0000);
    tv[7]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 3, 1, 0, 0, 0, 16'h0040, 16'h0002, 16'd100,  16'h0000);
    tv[8]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'd100,  16'd100);
    tv[9]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0040, 16'hFFFE, 16'd100,  16'h0000);
    tv[10] = mk(0, 1, 1, 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0040, 16'hFFFE, 16'd100,  16'h0042);
    tv[11] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0040, 16'hFFFE, 16'h0042, 16'h0042);
    tv[12] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0040, 16'h0000, 16'h0042, 16'd100);
    tv[13] = mk(0, 0, 2, 0, 16'h07FE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0042, 16'h0042);
    tv[14] = mk(0, 1, 2, 2, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF);
    tv[15] = mk(0, 1, 3, 5, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h1111);
    tv[16] = mk(0, 0, 3, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 4, 1, 0, 0, 0, 16'h1111, 16'h0000, 16'h0000, 16'h1111);
    tv[17] = mk(0, 0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 5, 1, 2, 1, 0, 16'h0020, 16'h0010, 16'h0000, 16'h1111);
    tv[18] = mk(0, 0, 0, 0, 16'h0008, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 2, 1, 3, 1, 0, 16'h0008, 16'h0030, 16'h0000, 16'h0000);
    tv[19] = mk(0, 0, 0, 0, 16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 2, 1, 4, 1, 0, 16'h0006, 16'h0004, 16'h0000, 16'h0000);
    tv[20] = mk(0, 1, 3, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 6, 1, 5, 1, 0, 16'h0006, 16'h0004, 16'h0000, 16'h000A);
    tv[21] = mk(0, 1, 2, 3, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 16'h0000, 7, 1, 7, 1, 0, 16'h0006, 16'h0004, 16'h0000, 16'h5A5A);
    tv[22] = mk(0, 1, 2, 6, 16'h000E, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6, 1, 6, 1, 0, 16'h0006, 16'h0004, 16'h0000, 16'h0F0F);
    tv[23] = mk(0, 1, 2, 7, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h0006, 16'h0004, 16'h5A5A, 16'h0000);
    tv[24] = mk(0, 0, 2, 1, 16'h000A, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 2, 0, 3, 0, 0, 16'h0006, 16'h0004, 16'h5A5A, 16'h000A);
    tv[25] = mk(1, 1, 2, 1, 16'h000A, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h000A);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      apply(tv[i]);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d pc", i),  pc_out,     tv[i].epc);
      chk($sformatf("v%0d sp", i),  sp_out,     tv[i].esp);
      chk($sformatf("v%0d ir", i),  Inst_out,   tv[i].eir);
      chk($sformatf("v%0d mem", i), MemVal_out, tv[i].emem);
    end

    // Read during a pending write shows the old word until the edge.
    @(negedge clock);
    apply(mk(0, 1, 2, 1, 16'h000A, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 16'h0000,
             0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    #1;
    chk("raw pre-edge", MemVal_out, 16'h000A);
    @(posedge clock);
    #1;
    chk("raw post-edge", MemVal_out, 16'h7777);

    // Enables off with arbitrary selects: nothing may move.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      reset = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; SPWrite = 1'b0; InstWrite = 1'b0;
      MemSrc = 2'd2; ze_imm = 16'h000A;
      MemDst = 3'($urandom_range(0, 7));
      PCSrc  = 3'($urandom_range(0, 7));
      SPSrc  = 3'($urandom_range(0, 7));
      MaryData = 16'($urandom); CompData = 16'($urandom); RAData = 16'($urandom);
      ls_imm = 16'($urandom); ShelleyData = 16'($urandom);
      @(posedge clock);
      #1;
      chk($sformatf("idle%0d pc", k),  pc_out,     16'h0000);
      chk($sformatf("idle%0d sp", k),  sp_out,     16'h0000);
      chk($sformatf("idle%0d ir", k),  Inst_out,   16'h0000);
      chk($sformatf("idle%0d mem", k), MemVal_out, 16'h7777);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
